nmea_field_extract: RTL and testbench

- Parametrised successor to the fixed GNRMC time decoder. Consumes the UART byte stream (op_flag/op_data) and matches a configurable 5-char NMEA sentence ID.
- Captures one configurable comma-delimited field of up to FIELD_MAX bytes and verifies the XOR checksum.
- Publishes the field atomically with a one-cycle valid pulse.
- Errors are reported with a pulse plus a code. Downstream display/BCD blocks consume field_data.

---
 rtl/nmea_field_extract.sv | 267 ++++++++++++++++++++++++++
 tb/tb_nmea_field_extract.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmea_field_extract.sv
// nmea_field_extract
//   Watches the UART byte stream for one NMEA sentence type (SENT_ID) and
//   captures field FIELD_IDX into a shadow buffer. The field is published to
//   field_data/field_len with a one-cycle field_valid pulse only after the
//   two-digit XOR checksum checks out. Rejected sentences give an err pulse
//   plus a held err_code.
//   FIELD_IDX must be >= 1; field 0 is the sentence ID and is never captured.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   op_flag      op_data valid strobe, one cycle per byte
//   op_data      received ASCII byte
//   field_data   captured field, first char in MS byte, unused bytes 8'h00
//   field_len    number of valid bytes in field_data
//   field_valid  one-cycle pulse, field_data/field_len updated this cycle
//   err          one-cycle pulse, sentence rejected
//   err_code     1 checksum, 2 non-hex, 3 overflow, 4 too long,
//                5 field missing, 6 status not 'A' (held until next err)
//
// Build option
//   NMEA_STATUS_GATE_EN  when defined, a valid sentence is only published if
//                        the first char of field STATUS_IDX is 'A'.
module nmea_field_extract #(
    parameter logic [39:0] SENT_ID    = 40'h474E524D43,
    parameter int          FIELD_IDX  = 1,
    parameter int          FIELD_MAX  = 10,
    parameter int          MAX_LEN    = 82,
    parameter int          STATUS_IDX = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   op_flag,
    input  logic [7:0]             op_data,
    output logic [8*FIELD_MAX-1:0] field_data,
    output logic [5:0]             field_len,
    output logic                   field_valid,
    output logic                   err,
    output logic [2:0]             err_code
);
    if (FIELD_MAX < 1 || FIELD_MAX > 32 || FIELD_IDX < 1 || MAX_LEN < 6 ||
        MAX_LEN > 254 || STATUS_IDX < 1) begin : g_bad_params
        $error("nmea_field_extract: parameter out of range");
    end

    localparam logic [7:0] FIELD_IDX_C = 8'(FIELD_IDX);
    localparam logic [5:0] FIELD_MAX_C = 6'(FIELD_MAX);
    localparam logic [7:0] MAX_LEN_C   = 8'(MAX_LEN);
    localparam logic [7:0] CH_DOLLAR   = 8'h24;
    localparam logic [7:0] CH_COMMA    = 8'h2C;
    localparam logic [7:0] CH_STAR     = 8'h2A;

    typedef enum logic [2:0] {IDLE, HDR, BODY, CHK_HI, CHK_LO} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             xor_q, xor_d;
    logic [7:0]             byte_cnt_q, byte_cnt_d;
    logic [2:0]             hdr_cnt_q, hdr_cnt_d;
    logic [7:0]             field_cnt_q, field_cnt_d;
    logic [8*FIELD_MAX-1:0] shadow_q, shadow_d;
    logic [5:0]             shadow_len_q, shadow_len_d;
    logic [3:0]             chk_hi_q, chk_hi_d;
    logic [8*FIELD_MAX-1:0] field_data_q, field_data_d;
    logic [5:0]             field_len_q, field_len_d;
    logic                   field_valid_q, field_valid_d;
    logic                   err_q, err_d;
    logic [2:0]             err_code_q, err_code_d;
`ifdef NMEA_STATUS_GATE_EN
    localparam logic [7:0] STATUS_IDX_C = 8'(STATUS_IDX);
    localparam logic [7:0] CH_A         = 8'h41;
    logic [7:0]             status_q, status_d;
    logic                   status_got_q, status_got_d;
`endif

    // {valid, nibble}; letters map via low nibble + 9 ('A'/'a' -> 10).
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
        if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        return 5'd0;
    endfunction

    logic [39:0] id_shift;
    logic [4:0]  hex_res;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        xor_d         = xor_q;
        byte_cnt_d    = byte_cnt_q;
        hdr_cnt_d     = hdr_cnt_q;
        field_cnt_d   = field_cnt_q;
        shadow_d      = shadow_q;
        shadow_len_d  = shadow_len_q;
        chk_hi_d      = chk_hi_q;
        field_data_d  = field_data_q;
        field_len_d   = field_len_q;
        field_valid_d = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
`ifdef NMEA_STATUS_GATE_EN
        status_d      = status_q;
        status_got_d  = status_got_q;
`endif
        // Expected header char for the current header position.
        id_shift = SENT_ID << {hdr_cnt_q, 3'b000};
        hex_res  = hex_decode(op_data);

        if (op_flag) begin
            if (op_data == CH_DOLLAR) begin
                // A new '$' silently aborts whatever sentence was in flight.
                state_d      = HDR;
                xor_d        = 8'd0;
                byte_cnt_d   = 8'd0;
                hdr_cnt_d    = 3'd0;
                field_cnt_d  = 8'd0;
                shadow_d     = '0;
                shadow_len_d = 6'd0;
`ifdef NMEA_STATUS_GATE_EN
                status_d     = 8'd0;
                status_got_d = 1'b0;
`endif
            end else if (state_q != IDLE) begin
                byte_cnt_d = byte_cnt_q + 8'd1;
                if (state_q != HDR && byte_cnt_q >= MAX_LEN_C) begin
                    err_d      = 1'b1;
                    err_code_d = 3'd4;
                    state_d    = IDLE;
                end else begin
                    case (state_q)
                        HDR: begin
                            xor_d = xor_q ^ op_data;
                            if (hdr_cnt_q == 3'd5) begin
                                if (op_data == CH_COMMA) begin
                                    state_d     = BODY;
                                    field_cnt_d = 8'd1;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (op_data != id_shift[39:32]) begin
                                state_d = IDLE;
                            end else begin
                                hdr_cnt_d = hdr_cnt_q + 3'd1;
                            end
                        end
                        BODY: begin
                            if (op_data == CH_STAR) begin
                                if (field_cnt_q < FIELD_IDX_C) begin
                                    err_d      = 1'b1;
                                    err_code_d = 3'd5;
                                    state_d    = IDLE;
                                end else begin
                                    state_d = CHK_HI;
                                end
                            end else begin
                                xor_d = xor_q ^ op_data;
                                if (op_data == CH_COMMA) begin
                                    field_cnt_d = field_cnt_q + 8'd1;
                                end else begin
`ifdef NMEA_STATUS_GATE_EN
                                    if (field_cnt_q == STATUS_IDX_C && !status_got_q) begin
                                        status_d     = op_data;
                                        status_got_d = 1'b1;
                                    end
`endif
                                    if (field_cnt_q == FIELD_IDX_C) begin
                                        if (shadow_len_q >= FIELD_MAX_C) begin
                                            err_d      = 1'b1;
                                            err_code_d = 3'd3;
                                            state_d    = IDLE;
                                        end else begin
                                            for (int i = 0; i < FIELD_MAX; i++)
                                                if (shadow_len_q == 6'(i))
                                                    shadow_d[8*(FIELD_MAX-1-i) +: 8] = op_data;
                                            shadow_len_d = shadow_len_q + 6'd1;
                                        end
                                    end
                                end
                            end
                        end
                        CHK_HI: begin
                            if (hex_res[4]) begin
                                chk_hi_d = hex_res[3:0];
                                state_d  = CHK_LO;
                            end else begin
                                err_d      = 1'b1;
                                err_code_d = 3'd2;
                                state_d    = IDLE;
                            end
                        end
                        CHK_LO: begin
                            state_d = IDLE;
                            if (!hex_res[4]) begin
                                err_d      = 1'b1;
                                err_code_d = 3'd2;
                            end else if ({chk_hi_q, hex_res[3:0]} != xor_q) begin
                                err_d      = 1'b1;
                                err_code_d = 3'd1;
`ifdef NMEA_STATUS_GATE_EN
                            end else if (status_q != CH_A) begin
                                err_d      = 1'b1;
                                err_code_d = 3'd6;
`endif
                            end else begin
                                // Whole field copied in one edge: never seen half-written.
                                field_data_d  = shadow_q;
                                field_len_d   = shadow_len_q;
                                field_valid_d = 1'b1;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            xor_q         <= 8'd0;
            byte_cnt_q    <= 8'd0;
            hdr_cnt_q     <= 3'd0;
            field_cnt_q   <= 8'd0;
            // NOTE: the shadow buffer is a register array, not RAM, so it can
            // and must be cleared by reset like every other flop.
            shadow_q      <= '0;
            shadow_len_q  <= 6'd0;
            chk_hi_q      <= 4'd0;
            field_data_q  <= '0;
            field_len_q   <= 6'd0;
            field_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 3'd0;
`ifdef NMEA_STATUS_GATE_EN
            status_q      <= 8'd0;
            status_got_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            xor_q         <= xor_d;
            byte_cnt_q    <= byte_cnt_d;
            hdr_cnt_q     <= hdr_cnt_d;
            field_cnt_q   <= field_cnt_d;
            shadow_q      <= shadow_d;
            shadow_len_q  <= shadow_len_d;
            chk_hi_q      <= chk_hi_d;
            field_data_q  <= field_data_d;
            field_len_q   <= field_len_d;
            field_valid_q <= field_valid_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
`ifdef NMEA_STATUS_GATE_EN
            status_q      <= status_d;
            status_got_q  <= status_got_d;
`endif
        end
    end

    assign field_data  = field_data_q;
    assign field_len   = field_len_q;
    assign field_valid = field_valid_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_nmea_field_extract.sv
// Testbench for nmea_field_extract. Three instances share one byte stream:
//   u0 defaults, u1 FIELD_MAX=1, u2 FIELD_IDX=3 (target field never present).
// A string-level sentence model predicts every output of every instance each
// cycle; literal checks in the main sequence pin the model's key answers.
module tb_nmea_field_extract;
    logic clk = 1'b0;
    logic rst_n;
    logic op_flag;
    logic [7:0] op_data;

    always #5 clk = ~clk;

    logic [79:0] d0_data; logic [5:0] d0_len; logic d0_valid, d0_err; logic [2:0] d0_code;
    logic [7:0]  d1_data; logic [5:0] d1_len; logic d1_valid, d1_err; logic [2:0] d1_code;
    logic [79:0] d2_data; logic [5:0] d2_len; logic d2_valid, d2_err; logic [2:0] d2_code;

    nmea_field_extract u0 (.clk(clk), .rst_n(rst_n), .op_flag(op_flag), .op_data(op_data),
        .field_data(d0_data), .field_len(d0_len), .field_valid(d0_valid), .err(d0_err), .err_code(d0_code));
    nmea_field_extract #(.FIELD_MAX(1)) u1 (.clk(clk), .rst_n(rst_n), .op_flag(op_flag), .op_data(op_data),
        .field_data(d1_data), .field_len(d1_len), .field_valid(d1_valid), .err(d1_err), .err_code(d1_code));
    nmea_field_extract #(.FIELD_IDX(3)) u2 (.clk(clk), .rst_n(rst_n), .op_flag(op_flag), .op_data(op_data),
        .field_data(d2_data), .field_len(d2_len), .field_valid(d2_valid), .err(d2_err), .err_code(d2_code));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- sentence model ----------------
    localparam int    MAX_LEN = 82;
    localparam int    STATUS_IDX = 2;
    localparam string SID = "GNRMC";
    int fmax_tab [3] = '{10, 1, 10};
    int fidx_tab [3] = '{1, 1, 3};

    typedef enum {R_NONE, R_IGNORE, R_VALID, R_ERR} res_e;

    function automatic int hexval(input byte c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // Text of comma-separated field idx within s[0..upto-1] (field 0 = ID).
    function automatic string get_field(input string s, input int upto, input int idx);
        string f = "";
        int k = 0;
        for (int i = 0; i < upto; i++) begin
            if (s[i] == 8'h2C) k++;
            else if (k == idx) f = $sformatf("%s%c", f, s[i]);
        end
        return f;
    endfunction

    // Verdict on the sentence body s (bytes after '$') as of its last byte.
    function automatic void eval(input string s, input int fmax, input int fidx,
                                 output res_e res, output int code, output string fld);
        int n = s.len();
        byte c = s[n-1];
        int p = -1;
        int commas = 0;
        int last_comma = -1;
        res = R_NONE; code = 0; fld = "";
        if (n <= 5) begin
            if (c != SID[n-1]) res = R_IGNORE;
            return;
        end
        if (n == 6) begin
            if (c != 8'h2C) res = R_IGNORE;
            return;
        end
        if (n > MAX_LEN) begin res = R_ERR; code = 4; return; end
        for (int i = 6; i < n - 1; i++)
            if (p < 0 && s[i] == 8'h2A) p = i;
        if (p < 0) begin
            for (int i = 0; i < n - 1; i++)
                if (s[i] == 8'h2C) begin commas++; last_comma = i; end
            if (c == 8'h2A) begin
                if (commas < fidx) begin res = R_ERR; code = 5; end
            end else if (c != 8'h2C && commas == fidx && (n - 1 - last_comma) > fmax) begin
                res = R_ERR; code = 3;
            end
            return;
        end
        if (hexval(c) < 0) begin res = R_ERR; code = 2; return; end
        if (n - 1 - p == 2) begin
            int x = 0;
            for (int i = 0; i < p; i++) x = x ^ int'(s[i]);
            if (x != hexval(s[p+1]) * 16 + hexval(c)) begin
                res = R_ERR; code = 1;
                return;
            end
`ifdef NMEA_STATUS_GATE_EN
            begin
                string st = get_field(s, p, STATUS_IDX);
                if (st.len() == 0 || st[0] != 8'h41) begin res = R_ERR; code = 6; return; end
            end
`endif
            res = R_VALID;
            fld = get_field(s, p, fidx);
        end
    endfunction

    function automatic logic [255:0] pack(input string f);
        logic [255:0] r = '0;
        for (int i = 0; i < f.len(); i++) r[255 - 8*i -: 8] = f[i];
        return r;
    endfunction

    bit    m_active [3];
    string m_buf    [3];
    bit    ev       [3];
    bit    ee       [3];
    int    ec       [3];
    string ef       [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_active[k] = 0; m_buf[k] = ""; ev[k] = 0; ee[k] = 0; ec[k] = 0; ef[k] = "";
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                ev[k] = 0; ee[k] = 0;
                if (op_flag) begin
                    if (op_data == 8'h24) begin
                        m_active[k] = 1; m_buf[k] = "";
                    end else if (m_active[k]) begin
                        res_e r; int code; string fld;
                        m_buf[k] = $sformatf("%s%c", m_buf[k], op_data);
                        eval(m_buf[k], fmax_tab[k], fidx_tab[k], r, code, fld);
                        case (r)
                            R_IGNORE: m_active[k] = 0;
                            R_ERR:    begin m_active[k] = 0; ee[k] = 1; ec[k] = code; end
                            R_VALID:  begin m_active[k] = 0; ev[k] = 1; ef[k] = fld; end
                            default:  ;
                        endcase
                    end
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input logic fv, input logic er, input logic [2:0] code,
                            input logic [5:0] len, input logic [255:0] data_al);
        check($sformatf("u%0d.field_valid", k), fv, ev[k]);
        check($sformatf("u%0d.err", k), er, ee[k]);
        check($sformatf("u%0d.err_code", k), code, ec[k][2:0]);
        check($sformatf("u%0d.field_len", k), len, ef[k].len());
        check($sformatf("u%0d.field_data", k), data_al, pack(ef[k]));
    endtask

    initial forever begin
        @(negedge clk); #1;
        cmp_inst(0, d0_valid, d0_err, d0_code, d0_len, {d0_data, 176'b0});
        cmp_inst(1, d1_valid, d1_err, d1_code, d1_len, {d1_data, 248'b0});
        cmp_inst(2, d2_valid, d2_err, d2_code, d2_len, {d2_data, 176'b0});
        check("never valid+err together", d0_valid & d0_err, 1'b0);
    end

    int vcnt = 0;
    always @(negedge clk) if (d0_valid === 1'b1) vcnt++;

    // ---------------- stimulus ----------------
    task automatic send_byte(input byte b);
        op_flag = 1'b1; op_data = b;
        @(negedge clk);
        op_flag = 1'b0;
    endtask

    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int v0;
        string long_s;
        rst_n = 1'b0; op_flag = 1'b0; op_data = 8'h00;
        idle(3);
        check("reset valid", d0_valid, 1'b0);
        check("reset err_code", d0_code, 3'd0);
        check("reset field_data", d0_data, 80'h0);
        rst_n = 1'b1;
        idle(2);

        // Default valid sentence; pulse one cycle after the '7' strobe.
        send("$GNRMC,12,A*1", 0);
        send_byte(8'h37); #1;
        check("first valid pulse", d0_valid, 1'b1);
        check("first len", d0_len, 6'd2);
        check("first data hi", d0_data[79:64], 16'h3132);
        check("first data rest", d0_data[63:0], 64'h0);
        check("fmax1 overflow code", d1_code, 3'd3);
        check("missing field code", d2_code, 3'd5);
        idle(2);

        send("$GNRMC,12,A*18", 0); idle(1);
        check("bad checksum code", d0_code, 3'd1);
        check("bad checksum keeps len", d0_len, 6'd2);

        v0 = vcnt;
        send("$GNRMC,12,V*00", 1); idle(2);
`ifdef NMEA_STATUS_GATE_EN
        check("status V code", d0_code, 3'd6);
`else
        check("status V ignored", vcnt - v0, 1);
`endif

        v0 = vcnt;
        send("$GNRMC,1$GNRMC,12,A*17", 0); idle(1);
        send("$GPGGA,12*5E", 0); idle(2);
        check("abort+foreign valid count", vcnt - v0, 1);

        send("$GNRMC,12,A*1G", 0); idle(1);
        check("non-hex code", d0_code, 3'd2);

        send("$GNRMC,,A*14", 2); idle(1);
        check("empty field len", d0_len, 6'd0);
        check("empty field data", d0_data, 80'h0);

        send("$GNRMC,9,A*2d", 0); idle(1);
        check("lowercase hex u1 data", d1_data, 8'h39);
        check("lowercase hex u0 data", d0_data[79:72], 8'h39);

        send("$GNRMC,0123456789,A*15", 0); idle(1);
        check("full field len", d0_len, 6'd10);
        check("full field last byte", d0_data[7:0], 8'h39);

        send("$GNRMC,01234567890,A*25", 0); idle(1);
        check("overflow code", d0_code, 3'd3);

        long_s = "$GNRMC,1,";
        for (int i = 0; i < 80; i++) long_s = {long_s, "B"};
        long_s = {long_s, "*00"};
        send(long_s, 0); idle(1);
        check("too long code", d0_code, 3'd4);

        // Reset mid-body, then the valid sentence with 0..5 idle gaps.
        send("$GNRMC,1", 0);
        rst_n = 1'b0; #1;
        check("mid reset len", d0_len, 6'd0);
        check("mid reset code", d0_code, 3'd0);
        check("mid reset data", d0_data, 80'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        v0 = vcnt;
        for (int g = 0; g <= 5; g++) begin
            send("$GNRMC,12,A*17", g); idle(2);
            check($sformatf("gap %0d len", g), d0_len, 6'd2);
        end
        check("gap valid count", vcnt - v0, 6);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
